// File: rtl/conv_acc_wb.sv
// Read-modify-write accumulator writeback stage. It reads the old partial sums,
// then adds or overwrites them per lane and writes them back with saturation.
// In-flight writes are forwarded so that back-to-back beats to one address accumulate correctly.

module conv_acc_wb_lane #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
) (
    input  logic                     en,
    input  logic                     acc_new,
    input  logic                     hit2,
    input  logic                     hit3,
    input  logic signed [DATA_W-1:0] data,
    input  logic signed [ACC_W-1:0]  rd_old,
    input  logic signed [ACC_W-1:0]  s2_old,
    input  logic signed [ACC_W-1:0]  s3_old,
    output logic signed [ACC_W-1:0]  result
);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W-1:0] old;
    logic signed [ACC_W-1:0] ext;
    logic signed [ACC_W:0]   wide;

    always_comb begin
        // Prefer the youngest write: S2 is issuing now, S3 issued last cycle.
        old  = hit2 ? s2_old : (hit3 ? s3_old : rd_old);
        ext  = ACC_W'(data);
        wide = (ACC_W+1)'(old) + (ACC_W+1)'(ext);
        if (!en)
            result = old;
        else if (acc_new)
            result = ext;
        else if (wide[ACC_W] != wide[ACC_W-1])
            result = wide[ACC_W] ? ACC_MIN : ACC_MAX;
        else
            result = wide[ACC_W-1:0];
    end
endmodule

module conv_acc_wb #(
    parameter int ADDR_W = 8,
    parameter int BATCH  = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [ADDR_W-1:0]       in_addr,
    input  logic [BATCH-1:0]        in_acc_en,
    input  logic                    in_acc_new,
    input  logic                    in_last,
    input  logic [BATCH*DATA_W-1:0] in_data,
    output logic [ADDR_W-1:0]       abuf_rd_addr,
    input  logic [BATCH*ACC_W-1:0]  abuf_rd_data,
    output logic                    abuf_wr_en,
    output logic [ADDR_W-1:0]       abuf_wr_addr,
    output logic [BATCH-1:0]        abuf_wr_mask,
    output logic [BATCH*ACC_W-1:0]  abuf_wr_data,
    output logic                    busy,
    output logic                    done
);
    logic                    s1_vld, s1_new, s1_last;
    logic [ADDR_W-1:0]       s1_addr;
    logic [BATCH-1:0]        s1_en;
    logic [BATCH*DATA_W-1:0] s1_data;

    logic                    s3_vld;
    logic [ADDR_W-1:0]       s3_addr;
    logic [BATCH-1:0]        s3_mask;
    logic [BATCH*ACC_W-1:0]  s3_data;

    logic [BATCH*ACC_W-1:0]  sum;
    logic [BATCH-1:0]        hit2, hit3;

    // The S2 stage is the write port itself, so abuf_wr_en doubles as S2 valid.
    assign abuf_rd_addr = rst ? '0 : in_addr;
    assign busy         = !rst && (in_valid || s1_vld || abuf_wr_en);

    for (genvar i = 0; i < BATCH; i++) begin : g_lane
        assign hit2[i] = abuf_wr_en && (abuf_wr_addr == s1_addr) && abuf_wr_mask[i];
        assign hit3[i] = s3_vld && (s3_addr == s1_addr) && s3_mask[i];

        conv_acc_wb_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_lane (
            .en      (s1_en[i]),
            .acc_new (s1_new),
            .hit2    (hit2[i]),
            .hit3    (hit3[i]),
            .data    (s1_data[i*DATA_W +: DATA_W]),
            .rd_old  (abuf_rd_data[i*ACC_W +: ACC_W]),
            .s2_old  (abuf_wr_data[i*ACC_W +: ACC_W]),
            .s3_old  (s3_data[i*ACC_W +: ACC_W]),
            .result  (sum[i*ACC_W +: ACC_W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld       <= 1'b0;
            s1_new       <= 1'b0;
            s1_last      <= 1'b0;
            s1_addr      <= '0;
            s1_en        <= '0;
            s1_data      <= '0;
            abuf_wr_en   <= 1'b0;
            abuf_wr_addr <= '0;
            abuf_wr_mask <= '0;
            abuf_wr_data <= '0;
            done         <= 1'b0;
            s3_vld       <= 1'b0;
            s3_addr      <= '0;
            s3_mask      <= '0;
            s3_data      <= '0;
        end else begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_new  <= in_acc_new;
                s1_last <= in_last;
                s1_addr <= in_addr;
                s1_en   <= in_acc_en;
                s1_data <= in_data;
            end

            abuf_wr_en <= s1_vld;
            done       <= s1_vld && s1_last;
            if (s1_vld) begin
                abuf_wr_addr <= s1_addr;
                abuf_wr_mask <= s1_en;
                abuf_wr_data <= sum;
            end

            s3_vld <= abuf_wr_en;
            if (abuf_wr_en) begin
                s3_addr <= abuf_wr_addr;
                s3_mask <= abuf_wr_mask;
                s3_data <= abuf_wr_data;
            end
        end
    end
endmodule

// File: tb/tb_conv_acc_wb.sv
// Randomized scoreboard bench for conv_acc_wb against a behavioural accumulate-buffer model.
module tb_conv_acc_wb;
    localparam int ADDR_W = 8, BATCH = 4, DATA_W = 16, ACC_W = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic                    clk = 0, rst = 1;
    logic                    in_valid = 0, in_acc_new = 0, in_last = 0;
    logic [ADDR_W-1:0]       in_addr = '0;
    logic [BATCH-1:0]        in_acc_en = '0;
    logic [BATCH*DATA_W-1:0] in_data = '0;
    logic [ADDR_W-1:0]       abuf_rd_addr;
    logic [BATCH*ACC_W-1:0]  abuf_rd_data = '0;
    logic                    abuf_wr_en, busy, done;
    logic [ADDR_W-1:0]       abuf_wr_addr;
    logic [BATCH-1:0]        abuf_wr_mask;
    logic [BATCH*ACC_W-1:0]  abuf_wr_data;

    conv_acc_wb #(.ADDR_W(ADDR_W), .BATCH(BATCH), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr), .in_acc_en(in_acc_en),
        .in_acc_new(in_acc_new), .in_last(in_last), .in_data(in_data),
        .abuf_rd_addr(abuf_rd_addr), .abuf_rd_data(abuf_rd_data), .abuf_wr_en(abuf_wr_en),
        .abuf_wr_addr(abuf_wr_addr), .abuf_wr_mask(abuf_wr_mask), .abuf_wr_data(abuf_wr_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Registered-read, read-first RAM
    logic [ACC_W-1:0] mem [256][BATCH];
    always @(posedge clk) begin
        for (int l = 0; l < BATCH; l++) begin
            abuf_rd_data[l*ACC_W +: ACC_W] <= mem[abuf_rd_addr][l];
            if (abuf_wr_en && abuf_wr_mask[l])
                mem[abuf_wr_addr][l] <= abuf_wr_data[l*ACC_W +: ACC_W];
        end
    end

    typedef struct {
        logic [ADDR_W-1:0]      addr;
        logic [BATCH-1:0]       mask;
        logic [BATCH*ACC_W-1:0] data;
        logic                   last;
    } exp_t;
    exp_t   q[$];
    longint ref_mem [256][BATCH];
    int     total = 0, passed = 0;

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic longint sat(longint v);
        return (v > SMAX) ? SMAX : ((v < SMIN) ? SMIN : v);
    endfunction

    task automatic preset(input int a, input int l, input logic [ACC_W-1:0] v);
        mem[a][l]     = v;
        ref_mem[a][l] = longint'($signed(v));
    endtask

    // Reference: the buffer is a plain array updated in issue order
    task automatic issue(input logic [ADDR_W-1:0] a, input logic [BATCH-1:0] en,
                         input logic nw, input logic last, input logic [BATCH*DATA_W-1:0] d);
        exp_t e;
        logic [DATA_W-1:0] dl;
        longint p;
        e.addr = a; e.mask = en; e.last = last; e.data = '0;
        for (int l = 0; l < BATCH; l++) begin
            dl = d[l*DATA_W +: DATA_W];
            p  = longint'($signed(dl));
            if (en[l]) ref_mem[a][l] = nw ? p : sat(ref_mem[a][l] + p);
            e.data[l*ACC_W +: ACC_W] = ref_mem[a][l][ACC_W-1:0];
        end
        q.push_back(e);
        in_valid = 1; in_addr = a; in_acc_en = en; in_acc_new = nw; in_last = last; in_data = d;
        @(posedge clk); #1;
        in_valid = 0; in_last = 0;
    endtask

    task automatic idle(input int n, input logic rnd_last);
        for (int k = 0; k < n; k++) begin
            in_valid = 0;
            in_last  = rnd_last ? 1'($urandom_range(0, 1)) : 1'b0;
            in_addr  = 8'($urandom_range(0, 3));
            @(posedge clk); #1;
        end
        in_last = 0;
    endtask

    function automatic logic [BATCH*DATA_W-1:0] rep(input logic [DATA_W-1:0] v);
        return {BATCH{v}};
    endfunction

    // Monitor: every write must match the head of the scoreboard
    always @(negedge clk) begin
        if (abuf_wr_en) begin
            if (q.size() == 0) begin
                check("unexpected_write", {120'd0, abuf_wr_addr}, 128'd0);
                check("unexpected_write_en", 128'(abuf_wr_en), 128'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("wr_addr", 128'(abuf_wr_addr), 128'(e.addr));
                check("wr_mask", 128'(abuf_wr_mask), 128'(e.mask));
                check("wr_data", abuf_wr_data, e.data);
                check("done", 128'(done), 128'(e.last));
            end
        end else if (done) begin
            check("done_without_write", 128'(done), 128'd0);
        end
    end

    initial begin
        int bad;
        for (int a = 0; a < 256; a++)
            for (int l = 0; l < BATCH; l++) preset(a, l, $urandom);

        // Reset state
        in_addr = 8'h55;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_wr_en", 128'(abuf_wr_en), 0);
        check("rst_wr_mask", 128'(abuf_wr_mask), 0);
        check("rst_wr_addr", 128'(abuf_wr_addr), 0);
        check("rst_wr_data", abuf_wr_data, 0);
        check("rst_done", 128'(done), 0);
        check("rst_busy", 128'(busy), 0);
        check("rst_rd_addr", 128'(abuf_rd_addr), 0);
        @(posedge clk); #1;
        rst = 0;
        idle(2, 0);

        // 1: simple accumulate
        for (int l = 0; l < BATCH; l++) preset(5, l, 32'd10);
        issue(8'd5, 4'b1111, 0, 0, rep(16'd3));
        idle(3, 0);
        check("t1_ram", 128'(mem[5][3]), 128'd13);

        // 2: three back-to-back beats to one address
        issue(8'd7, 4'b1111, 1, 0, rep(16'd1));
        issue(8'd7, 4'b1111, 0, 0, rep(16'd2));
        issue(8'd7, 4'b1111, 0, 0, rep(16'd4));
        idle(3, 0);
        for (int l = 0; l < BATCH; l++) check("t2_ram", 128'(mem[7][l]), 128'd7);

        // 3: partial mask then full mask
        preset(2, 2, 32'd100); preset(2, 3, 32'd100);
        issue(8'd2, 4'b0011, 1, 0, rep(16'd5));
        issue(8'd2, 4'b1111, 0, 0, rep(16'd1));
        idle(3, 0);
        check("t3_lane0", 128'(mem[2][0]), 128'd6);
        check("t3_lane2", 128'(mem[2][2]), 128'd101);

        // 4: saturation both directions
        preset(0, 0, 32'h7FFFFFF0); preset(0, 1, 32'h80000005);
        issue(8'd0, 4'b0011, 0, 0, {16'd0, 16'd0, 16'hFF9C, 16'd100});
        idle(3, 0);
        check("t4_pos_sat", 128'(mem[0][0]), 128'h7FFFFFFF);
        check("t4_neg_sat", 128'(mem[0][1]), 128'h80000000);

        // 5: done timing and busy fall
        issue(8'd9, 4'b0101, 0, 1, rep(16'($urandom)));
        @(negedge clk); check("t5_busy_t1", 128'(busy), 1);
        @(posedge clk); #1;
        @(negedge clk); check("t5_busy_t2", 128'(busy), 1);
        @(posedge clk); #1;
        @(negedge clk); check("t5_busy_t3", 128'(busy), 0);
        @(posedge clk); #1;
        issue(8'd9, 4'b1111, 0, 1, rep(16'd1));
        issue(8'd3, 4'b1111, 0, 1, rep(16'd2));
        idle(3, 0);

        // 6: reset while a beat is in flight
        in_valid = 1; in_addr = 8'd11; in_acc_en = 4'b1111; in_acc_new = 0; in_last = 1;
        in_data = rep(16'd7);
        @(posedge clk); #1;
        in_valid = 0; in_last = 0; in_addr = 0; rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("t6_wr_en", 128'(abuf_wr_en), 0);
        check("t6_done", 128'(done), 0);
        check("t6_busy", 128'(busy), 0);
        check("t6_wr_data", abuf_wr_data, 0);
        check("t6_wr_addr", 128'(abuf_wr_addr), 0);
        idle(3, 0);
        check("t6_ram", 128'(mem[11][0]), 128'(ref_mem[11][0][ACC_W-1:0]));

        // Random traffic on a few hot addresses near the saturation rails
        for (int a = 0; a < 4; a++)
            for (int l = 0; l < BATCH; l++)
                case ($urandom_range(0, 2))
                    0: preset(a, l, 32'h7FFF8000 + 32'($urandom_range(0, 32767)));
                    1: preset(a, l, 32'h80000000 + 32'($urandom_range(0, 32767)));
                    default: preset(a, l, $urandom);
                endcase
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0)
                idle($urandom_range(1, 3), 1);
            else
                issue(8'($urandom_range(0, 3)), 4'($urandom), ($urandom_range(0, 4) == 0),
                      ($urandom_range(0, 7) == 0), {$urandom, $urandom});
        end

        // Drain with a bounded wait
        for (int k = 0; k < 20 && q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        check("drain_empty", 128'(q.size()), 0);
        idle(2, 0);
        bad = 0;
        for (int a = 0; a < 256; a++)
            for (int l = 0; l < BATCH; l++)
                if (mem[a][l] !== ref_mem[a][l][ACC_W-1:0]) bad++;
        check("final_ram_mismatches", 128'(bad), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
